// File: rtl/bcd2gray_stream.sv
// rtl/bcd2gray_stream.sv - streaming BCD-to-Gray encoder with a small output buffer and transfer statistics
// Optional feature macro: BCD2GRAY_STEP_CHECK_EN (adds step_err, flags non-unit Hamming steps between delivered codes).
module bcd2gray_stream #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       in_bcd,
  output logic             in_ready,
  output logic             out_valid,
  output logic [3:0]       out_gray,
  output logic             out_err,
  input  logic             out_ready,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] err_cnt
`ifdef BCD2GRAY_STEP_CHECK_EN
  ,
  output logic             step_err
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [3:0]       gray_mem_q [DEPTH];
  logic [DEPTH-1:0] err_mem_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic [3:0]       head_gray_q;
  logic [3:0]       head_gray_d;
  logic             head_err_q;
  logic             head_err_d;
  logic [CNT_W-1:0] word_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;

  logic       push;
  logic       pop;
  logic [3:0] new_gray;
  logic       new_err;

  assign in_ready  = rst_n && (occ_q < OCC_W'(DEPTH));
  assign out_valid = (occ_q != '0);
  assign out_gray  = head_gray_q;
  assign out_err   = head_err_q;
  assign word_cnt  = word_cnt_q;
  assign err_cnt   = err_cnt_q;

  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign new_gray = {in_bcd[3], in_bcd[3] ^ in_bcd[2], in_bcd[2] ^ in_bcd[1], in_bcd[1] ^ in_bcd[0]};
  assign new_err  = (in_bcd > 4'd9);

  always_comb begin
    rd_ptr_d    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    occ_d       = occ_q;
    head_gray_d = head_gray_q;
    head_err_d  = head_err_q;
    if (push && !pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - OCC_W'(1);
    end
    // The head register tracks the next head; an incoming digit lands there only
    // when it becomes the oldest entry, which is exactly when wr_ptr meets rd_ptr_d.
    if (occ_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) begin
        head_gray_d = new_gray;
        head_err_d  = new_err;
      end else begin
        head_gray_d = gray_mem_q[rd_ptr_d];
        head_err_d  = err_mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        gray_mem_q[i] <= 4'd0;
      end
      err_mem_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      head_gray_q <= 4'd0;
      head_err_q  <= 1'b0;
      word_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (push) begin
        gray_mem_q[wr_ptr_q] <= new_gray;
        err_mem_q[wr_ptr_q]  <= new_err;
        wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
      end
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      head_gray_q <= head_gray_d;
      head_err_q  <= head_err_d;
      if (pop) begin
        word_cnt_q <= word_cnt_q + CNT_W'(1);
        if (head_err_q && (err_cnt_q != '1)) begin
          err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
      end
    end
  end

`ifdef BCD2GRAY_STEP_CHECK_EN
  logic [3:0] last_gray_q;
  logic       seen_q;
  logic       step_err_q;
  logic [3:0] step_diff;
  logic [2:0] step_dist;

  assign step_err  = step_err_q;
  assign step_diff = head_gray_q ^ last_gray_q;
  assign step_dist = {2'b00, step_diff[0]} + {2'b00, step_diff[1]}
                   + {2'b00, step_diff[2]} + {2'b00, step_diff[3]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_gray_q <= 4'd0;
      seen_q      <= 1'b0;
      step_err_q  <= 1'b0;
    end else if (pop) begin
      step_err_q  <= seen_q && (step_dist != 3'd1);
      last_gray_q <= head_gray_q;
      seen_q      <= 1'b1;
    end else begin
      step_err_q  <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_bcd2gray_stream.sv
// tb/tb_bcd2gray_stream.sv - randomized and directed self-checking bench for bcd2gray_stream
module tb_bcd2gray_stream;

  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [3:0]       in_bcd;
  logic             in_ready;
  logic             out_valid;
  logic [3:0]       out_gray;
  logic             out_err;
  logic             out_ready;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] err_cnt;
`ifdef BCD2GRAY_STEP_CHECK_EN
  logic             step_err;
`endif

  bcd2gray_stream #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_bcd    (in_bcd),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_gray  (out_gray),
    .out_err   (out_err),
    .out_ready (out_ready),
    .word_cnt  (word_cnt),
    .err_cnt   (err_cnt)
`ifdef BCD2GRAY_STEP_CHECK_EN
    ,
    .step_err  (step_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference: a queue of {err, gray}, plus plain-integer statistics.
  logic [4:0] exp_q [$];
  int         exp_words;
  int         exp_errs;
  logic [3:0] exp_last;
  bit         exp_seen;
  bit         exp_step;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] to_gray(input int b);
    return 4'((b ^ (b >> 1)) & 15);
  endfunction

  function automatic int hamming(input logic [3:0] a, input logic [3:0] b);
    int n = 0;
    for (int i = 0; i < 4; i++) if (a[i] != b[i]) n++;
    return n;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    exp_words = 0;
    exp_errs  = 0;
    exp_last  = 4'd0;
    exp_seen  = 0;
    exp_step  = 0;
  endtask

  // One clock cycle: drive, check at negedge, advance the model at posedge.
  task automatic step(input bit v, input int d, input bit r);
    bit         do_push;
    bit         do_pop;
    logic [4:0] head;
    in_valid  = v;
    in_bcd    = 4'(d);
    out_ready = r;
    @(negedge clk);
    check("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("out_gray", 32'(out_gray), 32'(exp_q[0][3:0]));
      check("out_err", 32'(out_err), 32'(exp_q[0][4]));
    end
    check("word_cnt", 32'(word_cnt), 32'(exp_words % 256));
    check("err_cnt", 32'(err_cnt), 32'(exp_errs));
`ifdef BCD2GRAY_STEP_CHECK_EN
    check("step_err", 32'(step_err), 32'(exp_step));
`endif
    do_push = v && (exp_q.size() < DEPTH);
    do_pop  = r && (exp_q.size() != 0);
    @(posedge clk);
    exp_step = 0;
    if (do_pop) begin
      head = exp_q.pop_front();
      exp_words++;
      if (head[4] && exp_errs < 255) exp_errs++;
      exp_step = exp_seen && (hamming(head[3:0], exp_last) != 1);
      exp_last = head[3:0];
      exp_seen = 1;
    end
    if (do_push) exp_q.push_back({d > 9, to_gray(d)});
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_bcd    = 4'd1;
    out_ready = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_word_cnt", 32'(word_cnt), 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
    end
    model_clear();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bcd    = 4'd0;
    out_ready = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    do_reset(3);
    step(0, 0, 0);

    for (int d = 0; d < 10; d++) step(1, d, 1);
    drain();
    check("word_cnt_after_0_9", 32'(word_cnt), 32'd10);

    step(1, 10, 1);
    step(1, 15, 1);
    drain();
    check("err_cnt_invalid", 32'(err_cnt), 32'd2);

    step(1, 3, 0);
    step(1, 4, 0);
    step(1, 5, 0);
    step(1, 5, 0);
    check("held_gray", 32'(out_gray), 32'h2);
    step(1, 5, 1);
    step(1, 5, 1);
    step(0, 0, 1);
    drain();

    step(1, 7, 0);
    step(1, 8, 0);
    step(0, 0, 0);
    do_reset(1);
    for (int i = 0; i < 3; i++) step(0, 0, 1);

    step(1, 2, 1);
    step(1, 3, 1);
    drain();
    step(1, 9, 1);
    step(1, 0, 1);
    drain();

    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) != 0, int'($urandom_range(0, 15)), ($urandom % 10) < 7);
    end
    drain();

    for (int i = 0; i < 700; i++) step(1, int'($urandom_range(10, 15)), 1);
    drain();
    check("err_cnt_saturated", 32'(err_cnt), 32'd255);

    for (int i = 0; i < 200; i++) begin
      step(($urandom % 2) != 0, int'($urandom_range(0, 15)), ($urandom % 3) != 0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd2gray_stream.md
Name: bcd2gray_stream

Overview:
- Streaming BCD-to-Gray encoder. It is the inverse of the Gray-to-BCD converter already in the design.
- Accepts one 4-bit BCD digit per transfer over a valid/ready input and emits the Gray code over a valid/ready output.
- A 2-entry output buffer decouples the two sides; the block also flags non-BCD digits and keeps transfer statistics.
- Sits between a digit source (counter, keypad decoder) and any Gray-code consumer (encoder model, position display).

Parameters:
- DEPTH, 2, output buffer entries; legal values are 2 or 4.
- CNT_W, 8, width of the transfer and error counters.

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  source presents a digit
- in_bcd  input  4  BCD digit; legal range 0..9
- in_ready  output  1  block can accept a digit this cycle
- out_valid  output  1  buffer head holds a result
- out_gray  output  4  Gray code of the buffer head
- out_err  output  1  buffer head came from a non-BCD digit (>9)
- out_ready  input  1  sink accepts the head this cycle
- word_cnt  output  CNT_W  output transfers completed
- err_cnt  output  CNT_W  error words delivered

Behaviour:
- Reset: synchronous, active-low. When rst_n=0 at a clk edge:
  - buffer is emptied and occupancy is set to 0;
  - out_valid=0, out_gray=0, out_err=0, word_cnt=0, err_cnt=0;
  - in_ready=0 in every cycle where rst_n=0, and returns to 1 in the first cycle after rst_n goes high.
- Reset mid-operation: everything buffered is discarded without being delivered; counters are cleared.
- Conversion: gray = {b[3], b[3]^b[2], b[2]^b[1], b[1]^b[0]}.
  - It is computed on in_bcd at push time and stored together with err = (in_bcd > 9).
- Invalid digits (10..15) are still converted, stored and delivered, with out_err=1. They are never dropped.
- Push: an input transfer occurs when in_valid && in_ready at a clk edge.
- Pop: an output transfer occurs when out_valid && out_ready at a clk edge.
- in_ready = (occupancy < DEPTH). It is combinational from registered state only and never depends on in_valid or out_ready.
- out_valid = (occupancy != 0). out_gray and out_err are driven from the head entry register.
  - When out_valid=0, out_gray and out_err hold their last values; the bench must not check them then.
- Latency: a digit pushed at edge N into an empty buffer has out_valid=1 and the correct out_gray after edge N (one cycle).
- Order: FIFO; results leave in arrival order.
- Simultaneous push and pop when 0 < occupancy < DEPTH: occupancy is unchanged and both take effect.
- Full buffer: in_ready=0, so no push can occur. A pop at this edge makes in_ready=1 in the next cycle (no same-cycle pass-through).
- Empty buffer: a pop cannot occur. Push only.
- Stable output: while out_valid=1 and out_ready=0, out_gray and out_err stay stable.
- Pointers: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Counters, updated on each pop:
  - word_cnt increments by 1 and wraps from 2^CNT_W-1 to 0.
  - err_cnt increments when the popped entry has err=1, and saturates at 2^CNT_W-1.

Optional Feature:
- Macro: BCD2GRAY_STEP_CHECK_EN.
- Defined:
  - adds output port step_err (1 bit, registered, reset 0) and a 4-bit register holding the last delivered Gray code, plus a "first word since reset" flag;
  - on each pop after the first since reset, step_err is set to 1 for one cycle if the Hamming distance between the popped code and the previous one is not exactly 1; otherwise it is 0.
- Not defined: step_err and its logic are absent, and the port list is exactly as above.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, word_cnt=0, err_cnt=0; after release, in_ready=1 and out_valid=0 with no push yet.
- Full sequence: push 0..9 with out_ready=1 -> out_gray = 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, each one cycle after its push; out_err=0; word_cnt=10.
- Invalid digits: push 1010, then 1111 -> out_gray=1111 with out_err=1, then 1000 with out_err=1; err_cnt=2.
- Backpressure: out_ready=0, push 3, 4, 5 -> in_ready drops after 2 pushes; digit 5 is held at the source; out_gray=0010 stays stable; then out_ready=1 -> 0010, 0110, 0111 in order.
- Reset mid-stream: buffer full with 7 and 8, assert rst_n=0 for one cycle -> out_valid=0 and counters=0 after the edge; neither word is ever delivered.
- Step check (macro defined): deliver 2 then 3 -> step_err stays 0; deliver 9 then 0 (1101 to 0000) -> step_err=1 for one cycle.
